// File: rtl/argmax_layer.sv
// Serial argmax over one captured score vector, result held under a valid/yumi handshake.
// Optional ARGMAX_MARGIN_EN adds a second-best tracker and the saturated margin_o output.
module argmax_layer #(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned INT_BITS     = 4,
    parameter int unsigned LAYER_HEIGHT = 10,
    localparam int unsigned INDEX_WIDTH = $clog2(LAYER_HEIGHT)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [LAYER_HEIGHT*WORD_SIZE-1:0] data_i,
    output logic                             valid_o,
    input  logic                             yumi_i,
    output logic [INDEX_WIDTH-1:0]           class_o,
    output logic [WORD_SIZE-1:0]             data_o
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [WORD_SIZE-1:0]             margin_o
`endif
);

    if (LAYER_HEIGHT < 2) begin : g_bad_height
        $error("argmax_layer: LAYER_HEIGHT must be at least 2");
    end
    if (INT_BITS < 1 || INT_BITS > WORD_SIZE) begin : g_bad_int_bits
        $error("argmax_layer: INT_BITS must lie in 1..WORD_SIZE");
    end

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(LAYER_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t                                   state_q, state_d;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]   vec_q, vec_d;
    logic [INDEX_WIDTH-1:0]                   idx_q, idx_d;
    logic signed [WORD_SIZE-1:0]              best_q, best_d;
    logic [INDEX_WIDTH-1:0]                   best_idx_q, best_idx_d;
    logic [INDEX_WIDTH-1:0]                   class_q, class_d;
    logic [WORD_SIZE-1:0]                     data_q, data_d;
    logic signed [WORD_SIZE-1:0]              cand;

`ifdef ARGMAX_MARGIN_EN
    localparam logic [WORD_SIZE-1:0] MOST_NEG = {1'b1, {(WORD_SIZE-1){1'b0}}};
    localparam logic [WORD_SIZE-1:0] MOST_POS = {1'b0, {(WORD_SIZE-1){1'b1}}};

    logic signed [WORD_SIZE-1:0]              second_q, second_d;
    logic [WORD_SIZE-1:0]                     margin_q, margin_d;
    logic signed [WORD_SIZE:0]                diff;
`endif

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        class_d    = class_q;
        data_d     = data_q;
        cand       = vec_q[idx_q];
`ifdef ARGMAX_MARGIN_EN
        second_d   = second_q;
        margin_d   = margin_q;
        diff       = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    vec_d      = data_i;
                    best_d     = data_i[WORD_SIZE-1:0];
                    best_idx_d = '0;
                    idx_d      = INDEX_WIDTH'(1);
                    state_d    = SCAN;
`ifdef ARGMAX_MARGIN_EN
                    second_d   = MOST_NEG;
`endif
                end
            end
            SCAN: begin
                if (cand > best_q) begin
                    best_d     = cand;
                    best_idx_d = idx_q;
`ifdef ARGMAX_MARGIN_EN
                    second_d   = best_q;
                end else if (cand > second_q) begin
                    second_d   = cand;
`endif
                end
                if (idx_q == LAST_IDX) begin
                    // Result registers load from the final comparison so they stay quiet during scans.
                    state_d = DONE;
                    idx_d   = '0;
                    class_d = best_idx_d;
                    data_d  = best_d;
`ifdef ARGMAX_MARGIN_EN
                    // best >= second, so diff is non-negative; bit WORD_SIZE-1 flags overflow.
                    diff     = {best_d[WORD_SIZE-1], best_d} - {second_d[WORD_SIZE-1], second_d};
                    margin_d = diff[WORD_SIZE-1] ? MOST_POS : diff[WORD_SIZE-1:0];
`endif
                end else begin
                    idx_d = idx_q + INDEX_WIDTH'(1);
                end
            end
            DONE: begin
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            class_q    <= '0;
            data_q     <= '0;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= '0;
            margin_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            class_q    <= class_d;
            data_q     <= data_d;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= second_d;
            margin_q   <= margin_d;
`endif
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign class_o = class_q;
    assign data_o  = data_q;
`ifdef ARGMAX_MARGIN_EN
    assign margin_o = margin_q;
`endif

endmodule
